// File: rtl/spike_dispatcher.sv
// Transmit side of the neuron-matrix spike path: latches a spike vector and walks
// the adjacency matrix, emitting one (src, dst, weight) event per handshake.
module spike_dispatcher #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  spikes,
    input  logic          spikes_valid,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_src,
    input  logic [AW-1:0] cfg_dst,
    input  logic          cfg_en,
    input  logic [W-1:0]  cfg_weight,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_src,
    output logic [AW-1:0] out_dst,
    output logic [W-1:0]  out_weight,
    output logic          busy,
    output logic          done,
    output logic [7:0]    drop_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state;
    logic [N-1:0]  spk_reg;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [N-1:0]  adj_en [N];
    logic [W-1:0]  adj_w  [N][N];

    logic          advance;
    logic          row_end;
    logic          last_pair;
    logic [AW-1:0] src_n;
    logic [AW-1:0] dst_n;

    // Valid/ready: an event is offered while out_valid is high and is consumed on a
    // rising edge where out_valid && out_ready; the pair never changes before that.
    always_comb begin
        advance   = !out_valid || out_ready;
        row_end   = !spk_reg[src] || (dst == LAST);
        last_pair = row_end && (src == LAST);
        src_n     = row_end ? src + 1'b1 : src;
        dst_n     = row_end ? '0 : dst + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                adj_en[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    adj_w[i][j] <= '0;
                end
            end
        end else if (state == IDLE && cfg_we && cfg_src != cfg_dst) begin
            adj_en[cfg_src][cfg_dst] <= cfg_en;
            adj_w[cfg_src][cfg_dst]  <= cfg_weight;
        end
    end

    // The out_* registers are loaded with the pair the pointer is about to move to,
    // so each scanned pair is presented in the very cycle the pointer sits on it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            spk_reg    <= '0;
            src        <= '0;
            dst        <= '0;
            out_valid  <= 1'b0;
            out_src    <= '0;
            out_dst    <= '0;
            out_weight <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            drop_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (spikes_valid) begin
                        spk_reg    <= spikes;
                        src        <= '0;
                        dst        <= '0;
                        busy       <= 1'b1;
                        out_valid  <= 1'b0;
                        out_src    <= '0;
                        out_dst    <= '0;
                        out_weight <= '0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (spikes_valid && drop_count != 8'hff) begin
                        drop_count <= drop_count + 8'd1;
                    end
                    if (advance) begin
                        if (last_pair) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            src        <= src_n;
                            dst        <= dst_n;
                            out_valid  <= spk_reg[src_n] && adj_en[src_n][dst_n];
                            out_src    <= src_n;
                            out_dst    <= dst_n;
                            out_weight <= adj_w[src_n][dst_n];
                        end
                    end
                end
                DONE: begin
                    if (spikes_valid && drop_count != 8'hff) begin
                        drop_count <= drop_count + 8'd1;
                    end
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: event order, stalls, drops, config gating,
// reset abort and full-mesh scan timing.
module tb_spike_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] spikes;
    logic       spikes_valid;
    logic       cfg_we;
    logic [1:0] cfg_src;
    logic [1:0] cfg_dst;
    logic       cfg_en;
    logic [7:0] cfg_weight;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_src;
    logic [1:0] out_dst;
    logic [7:0] out_weight;
    logic       busy;
    logic       done;
    logic [7:0] drop_count;

    int compared = 0;
    int mismatched = 0;
    int n;

    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];

    spike_dispatcher dut (
        .clk(clk), .reset(reset), .spikes(spikes), .spikes_valid(spikes_valid),
        .cfg_we(cfg_we), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_en(cfg_en),
        .cfg_weight(cfg_weight), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src), .out_dst(out_dst), .out_weight(out_weight),
        .busy(busy), .done(done), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] s, input logic [1:0] d, input logic en,
                             input logic [7:0] w);
        cfg_we = 1'b1; cfg_src = s; cfg_dst = d; cfg_en = en; cfg_weight = w;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] vec);
        spikes = vec;
        spikes_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        spikes_valid = 1'b0;
        cfg_we = 1'b0;
        check("busy_after_strobe", 32'(busy), 32'd1);
    endtask

    // Runs until done is seen, recording handshakes; n counts edges since the strobe.
    task automatic run_to_done(input int stall, inout int cnt);
        logic [11:0] held;
        int left;
        logic holding;
        left = stall;
        holding = 1'b0;
        held = '0;
        while (!done && cnt < 100) begin
            if (holding) check("stall_hold", 32'({out_valid, out_src, out_dst, out_weight}),
                               32'({1'b1, held}));
            if (out_valid && left > 0) begin
                if (!holding) begin
                    holding = 1'b1;
                    held = {out_src, out_dst, out_weight};
                end
                left--;
                out_ready = 1'b0;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                got_q.push_back({out_src, out_dst, out_weight});
                holding = 1'b0;
            end
            tick();
            cnt++;
        end
        out_ready = 1'b1;
        check("done_seen", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic finish_done();
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic dispatch(input logic [3:0] vec, input int stall, output int cnt);
        strobe(vec);
        cnt = 1;
        run_to_done(stall, cnt);
        finish_done();
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_event"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        reset = 1'b1; spikes = '0; spikes_valid = 1'b0; cfg_we = 1'b0;
        cfg_src = '0; cfg_dst = '0; cfg_en = 1'b0; cfg_weight = '0; out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_fields", 32'({out_src, out_dst, out_weight}), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);

        // Basic fan-out: two events from neuron 0, done 8 edges after the strobe.
        cfg_write(2'd0, 2'd1, 1'b1, 8'd5);
        cfg_write(2'd0, 2'd3, 1'b1, 8'd9);
        dispatch(4'b0001, 0, n);
        exp_q.push_back({2'd0, 2'd1, 8'd5});
        exp_q.push_back({2'd0, 2'd3, 8'd9});
        compare_events("basic");
        check("basic_latency", 32'(n), 32'd8);

        // Backpressure: ready low for 3 cycles on the first event.
        dispatch(4'b0001, 3, n);
        exp_q.push_back({2'd0, 2'd1, 8'd5});
        exp_q.push_back({2'd0, 2'd3, 8'd9});
        compare_events("stall");
        check("stall_latency", 32'(n), 32'd11);

        // Strobes in SCAN and in the DONE cycle are dropped.
        strobe(4'b0001);
        spikes_valid = 1'b1;
        tick();
        spikes_valid = 1'b0;
        n = 2;
        run_to_done(0, n);
        spikes_valid = 1'b1;
        tick();
        spikes_valid = 1'b0;
        check("drop_done_pulse", 32'(done), 32'd0);
        check("drop_not_started", 32'(busy), 32'd0);
        check("drop_count_2", 32'(drop_count), 32'd2);
        exp_q.push_back({2'd0, 2'd1, 8'd5});
        exp_q.push_back({2'd0, 2'd3, 8'd9});
        compare_events("drop");
        check("drop_latency", 32'(n), 32'd8);
        dispatch(4'b0001, 0, n);
        exp_q.push_back({2'd0, 2'd1, 8'd5});
        exp_q.push_back({2'd0, 2'd3, 8'd9});
        compare_events("after_drop");
        check("after_drop_latency", 32'(n), 32'd8);
        check("after_drop_count", 32'(drop_count), 32'd2);

        // Self-connection write ignored; write during SCAN ignored.
        cfg_write(2'd2, 2'd2, 1'b1, 8'h77);
        strobe(4'b0110);
        cfg_we = 1'b1; cfg_src = 2'd1; cfg_dst = 2'd0; cfg_en = 1'b1; cfg_weight = 8'd3;
        tick();
        cfg_we = 1'b0;
        n = 2;
        run_to_done(0, n);
        finish_done();
        compare_events("cfg_scan");
        check("cfg_scan_latency", 32'(n), 32'd11);
        dispatch(4'b0110, 0, n);
        compare_events("cfg_scan_next");

        // Re-write in IDLE, plus a write coincident with the strobe.
        cfg_write(2'd1, 2'd0, 1'b1, 8'd3);
        cfg_we = 1'b1; cfg_src = 2'd2; cfg_dst = 2'd3; cfg_en = 1'b1; cfg_weight = 8'h42;
        strobe(4'b0110);
        n = 1;
        run_to_done(0, n);
        finish_done();
        exp_q.push_back({2'd1, 2'd0, 8'd3});
        exp_q.push_back({2'd2, 2'd3, 8'h42});
        compare_events("cfg_idle");
        check("cfg_idle_latency", 32'(n), 32'd11);

        // Reset mid-SCAN while an event is pending; strobe during reset is ignored.
        strobe(4'b0001);
        out_ready = 1'b0;
        tick();
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        check("pre_reset_pair", 32'({out_src, out_dst, out_weight}), 32'({2'd0, 2'd1, 8'd5}));
        reset = 1'b1;
        spikes_valid = 1'b1;
        tick();
        spikes_valid = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_drop_count", 32'(drop_count), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        check("reset_strobe_ignored", 32'(busy), 32'd0);
        dispatch(4'b1111, 0, n);
        compare_events("cleared");
        check("cleared_latency", 32'(n), 32'd17);

        // Full mesh: 12 events in row-major order with distinct weights.
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 4; d++) begin
                if (s != d) begin
                    cfg_write(2'(s), 2'(d), 1'b1, 8'(8'h20 + s * 4 + d));
                    exp_q.push_back({2'(s), 2'(d), 8'(8'h20 + s * 4 + d)});
                end
            end
        end
        dispatch(4'b1111, 0, n);
        compare_events("mesh");
        check("mesh_latency", 32'(n), 32'd17);
        check("mesh_drop_count", 32'(drop_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
